dma_pcis_wrcombine_ctrl: RTL

Write-combining controller in front of the PCIS DMA write path. It accepts 512-bit beats with 64-bit byte strobes and merges consecutive beats that target the same 64-byte line into one buffered line. It emits one unified beat with a merged strobe when any of these occurs: the line is full, the address changes, an idle timeout expires, or an explicit flush is requested. It sits between the PCIS slave beat stream and the downstream DMA write consumer.

---
 rtl/dma_pcis_wrcombine_ctrl_pkg.sv | 14 +
 rtl/dma_pcis_wrcombine_ctrl_lane.sv | 11 +
 rtl/dma_pcis_wrcombine_ctrl.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/dma_pcis_wrcombine_ctrl_pkg.sv
// Shared types for the PCIS DMA write-combining controller.
package dma_pcis_wrcombine_ctrl_pkg;
  localparam int WC_LINE_OFFSET_BITS = 6;
  localparam int WC_DATA_BYTES       = 64;
  localparam int WC_ADDR_WIDTH       = 64;

  typedef enum logic [1:0] {WC_IDLE, WC_ACCUM, WC_FLUSH} WrCombState;

  typedef struct packed {
    logic [WC_DATA_BYTES*8-1:0] data;
    logic [WC_ADDR_WIDTH-1:0]   addr;
    logic [WC_DATA_BYTES-1:0]   strb;
  } WrCombBeat;
endpackage

// File: rtl/dma_pcis_wrcombine_ctrl_lane.sv
// One byte lane of the line buffer; written when its strobe is accepted, never reset.
module dma_pcis_wrcomb_lane (
  input  logic       clk,
  input  logic       we,
  input  logic [7:0] d,
  output logic [7:0] q
);
  always_ff @(posedge clk) begin
    if (we) q <= d;
  end
endmodule

// File: rtl/dma_pcis_wrcombine_ctrl.sv
// Write-combining controller merging same-line PCIS beats into one masked line.
// Optional statistics counters: define DMA_PCIS_WRCOMB_STATS_EN.
//
// state    | meaning
// WC_IDLE  | no pending line, accepting the first beat of a new line
// WC_ACCUM | line partially filled, merging same-line beats, timer running
// WC_FLUSH | presenting the merged line until downstream grant
module dma_pcis_wrcombine_ctrl
  import dma_pcis_wrcombine_ctrl_pkg::*;
#(
  parameter int DATA_BYTES     = WC_DATA_BYTES,
  parameter int ADDR_WIDTH     = WC_ADDR_WIDTH,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DATA_BYTES*8-1:0] packet_in,
  input  logic [ADDR_WIDTH-1:0]   addr_in,
  input  logic [DATA_BYTES-1:0]   wrstrb_in,
  input  logic                    packet_in_valid,
  output logic                    packet_in_grant,
  input  logic                    flush_req,
  output logic [DATA_BYTES*8-1:0] packet_out,
  output logic [ADDR_WIDTH-1:0]   addr_out,
  output logic [DATA_BYTES-1:0]   wrstrb_out,
  output logic                    packet_out_valid,
  input  logic                    packet_out_grant,
  output logic                    busy
`ifdef DMA_PCIS_WRCOMB_STATS_EN
  ,
  output logic [31:0]             stat_beats_in,
  output logic [31:0]             stat_lines_out,
  output logic [31:0]             stat_timeouts
`endif
);
  localparam int LINE_W = ADDR_WIDTH - WC_LINE_OFFSET_BITS;
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

  WrCombState            state;
  logic [DATA_BYTES-1:0] mask;
  logic [DATA_BYTES-1:0] mask_nxt;
  logic [DATA_BYTES-1:0] lane_we;
  logic [7:0]            timer;
  logic [LINE_W-1:0]     line_q;
  logic [LINE_W-1:0]     line_in;
  logic                  other_line;
  logic                  grant_c;
  logic                  accept;
  logic                  timeout_hit;
  logic                  unused_addr_lsbs;

  assign unused_addr_lsbs = ^addr_in[WC_LINE_OFFSET_BITS-1:0];

  always_comb begin
    line_in    = addr_in[ADDR_WIDTH-1:WC_LINE_OFFSET_BITS];
    other_line = packet_in_valid && (line_in != line_q);
    grant_c    = 1'b0;
    case (state)
      WC_IDLE:  grant_c = 1'b1;
      WC_ACCUM: grant_c = !flush_req && !other_line;
      default:  grant_c = 1'b0;
    endcase
  end

  // Grant is forced low while reset is held, even though IDLE would grant.
  assign packet_in_grant = grant_c & rst;
  assign accept          = packet_in_valid & packet_in_grant;
  assign lane_we         = accept ? wrstrb_in : '0;
  assign mask_nxt        = mask | wrstrb_in;
  // In ACCUM the only non-accepting, non-flushing case is an absent input beat.
  assign timeout_hit     = (state == WC_ACCUM) && !flush_req && !packet_in_valid &&
                           (timer == TO_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state            <= WC_IDLE;
      mask             <= '0;
      timer            <= '0;
      line_q           <= '0;
      packet_out_valid <= 1'b0;
      busy             <= 1'b0;
    end else begin
      case (state)
        WC_IDLE: begin
          if (accept && (|wrstrb_in)) begin
            mask   <= wrstrb_in;
            line_q <= line_in;
            timer  <= '0;
            busy   <= 1'b1;
            if (&wrstrb_in) begin
              state            <= WC_FLUSH;
              packet_out_valid <= 1'b1;
            end else begin
              state <= WC_ACCUM;
            end
          end
        end
        WC_ACCUM: begin
          if (flush_req || other_line) begin
            state            <= WC_FLUSH;
            packet_out_valid <= 1'b1;
          end else if (accept) begin
            mask  <= mask_nxt;
            timer <= '0;
            if (&mask_nxt) begin
              state            <= WC_FLUSH;
              packet_out_valid <= 1'b1;
            end
          end else begin
            if (timer != 8'hFF) timer <= timer + 8'd1;
            if (timeout_hit) begin
              state            <= WC_FLUSH;
              packet_out_valid <= 1'b1;
            end
          end
        end
        WC_FLUSH: begin
          if (packet_out_grant) begin
            mask             <= '0;
            state            <= WC_IDLE;
            packet_out_valid <= 1'b0;
            busy             <= 1'b0;
          end
        end
        default: begin
          state            <= WC_IDLE;
          packet_out_valid <= 1'b0;
          busy             <= 1'b0;
        end
      endcase
    end
  end

  genvar i;
  for (i = 0; i < DATA_BYTES; i++) begin : g_lane
    logic [7:0] q;
    dma_pcis_wrcomb_lane u_lane (
      .clk (clk),
      .we  (lane_we[i]),
      .d   (packet_in[i*8 +: 8]),
      .q   (q)
    );
    assign packet_out[i*8 +: 8] = mask[i] ? q : 8'h00;
  end

  assign addr_out   = {line_q, {WC_LINE_OFFSET_BITS{1'b0}}};
  assign wrstrb_out = mask;

`ifdef DMA_PCIS_WRCOMB_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_beats_in  <= '0;
      stat_lines_out <= '0;
      stat_timeouts  <= '0;
    end else begin
      if (accept && (|wrstrb_in))             stat_beats_in  <= stat_beats_in + 32'd1;
      if (packet_out_valid && packet_out_grant) stat_lines_out <= stat_lines_out + 32'd1;
      if (timeout_hit)                        stat_timeouts  <= stat_timeouts + 32'd1;
    end
  end
`endif
endmodule
